// File: rtl/em4100_pkg.sv
// Shared frame constants, error codes, FSM state type and parity/ID helpers for the EM4100 receiver.
// The helpers are purely combinational and are evaluated on the captured 55-bit frame body.
package em4100_pkg;
    localparam int HEADER_LEN = 9;
    localparam int ROWS       = 10;
    localparam int COLS       = 4;
    localparam int FRAME_BITS = 55;
    localparam int ID_BITS    = 40;

    localparam logic [1:0] ERR_STOP = 2'b00;
    localparam logic [1:0] ERR_LINE = 2'b01;
    localparam logic [1:0] ERR_ROW  = 2'b10;
    localparam logic [1:0] ERR_COL  = 2'b11;

    typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_CHECK} frame_state_t;

    function automatic logic row_par_ok(input logic [FRAME_BITS-1:0] f);
        logic ok;
        ok = 1'b1;
        for (int r = 0; r < ROWS; r++)
            if (^f[5*r +: 5]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic col_par_ok(input logic [FRAME_BITS-1:0] f);
        logic ok;
        logic p;
        ok = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            p = f[5*ROWS + c];
            for (int r = 0; r < ROWS; r++)
                p = p ^ f[5*r + c];
            if (p) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [ID_BITS-1:0] extract_id(input logic [FRAME_BITS-1:0] f);
        logic [ID_BITS-1:0] id;
        id = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                id[4*r + c] = f[5*r + c];
        return id;
    endfunction
endpackage

// File: rtl/em4100_manchester_rx.sv
// Manchester bit recovery: synchroniser, run counter, run classifier and phase tracker.
// Bit strobe 3 clk after the line edge; no backpressure, bits are dropped if not consumed.
module em4100_manchester_rx #(
    parameter int HALF_CYC = 16,
    parameter int TOL      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_din,
    output logic o_bit,
    output logic o_bit_stb,
    output logic o_line_err,
    output logic o_idle,
    output logic o_locked
);
    localparam int CW = $clog2(2*HALF_CYC + TOL + 2);
    localparam logic [CW-1:0] SAT_V = CW'(2*HALF_CYC + TOL + 1);
    localparam logic [CW-1:0] S_LO  = CW'(HALF_CYC - TOL);
    localparam logic [CW-1:0] S_HI  = CW'(HALF_CYC + TOL);
    localparam logic [CW-1:0] L_LO  = CW'(2*HALF_CYC - TOL);
    localparam logic [CW-1:0] L_HI  = CW'(2*HALF_CYC + TOL);

    if (TOL >= HALF_CYC/2) begin : g_bad_tol
        $error("em4100_manchester_rx: TOL must be less than HALF_CYC/2");
    end

    logic          r_sync1, r_sync2, r_prev;
    logic [CW-1:0] r_cnt;
    logic          r_locked, r_mid, r_armed;
    logic          r_bit, r_stb, r_lerr, r_idle;
    logic          w_edge, w_short, w_long;

    assign w_edge  = r_sync2 ^ r_prev;
    assign w_short = (r_cnt >= S_LO) && (r_cnt <= S_HI);
    assign w_long  = (r_cnt >= L_LO) && (r_cnt <= L_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // r_cnt holds the run length at an edge; r_armed permits relock only after idle/reset/enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= SAT_V;
            r_locked <= 1'b0;
            r_mid    <= 1'b0;
            r_armed  <= 1'b1;
            r_bit    <= 1'b0;
            r_stb    <= 1'b0;
            r_lerr   <= 1'b0;
            r_idle   <= 1'b0;
        end else begin
            r_stb  <= 1'b0;
            r_lerr <= 1'b0;
            r_idle <= 1'b0;
            if (!i_en) begin
                r_cnt    <= SAT_V;
                r_locked <= 1'b0;
                r_mid    <= 1'b0;
                r_armed  <= 1'b1;
            end else if (w_edge) begin
                r_cnt <= CW'(1);
                if (!r_locked && r_armed) begin
                    r_locked <= 1'b1;
                    r_armed  <= 1'b0;
                    r_mid    <= 1'b1;
                    r_bit    <= r_sync2;
                    r_stb    <= 1'b1;
                end else if (r_locked) begin
                    if (w_short && r_mid) begin
                        r_mid <= 1'b0;
                    end else if (w_short || (w_long && r_mid)) begin
                        r_mid <= 1'b1;
                        r_bit <= r_sync2;
                        r_stb <= 1'b1;
                    end else begin
                        r_lerr   <= 1'b1;
                        r_locked <= 1'b0;
                    end
                end
            end else begin
                if (r_cnt != SAT_V) r_cnt <= r_cnt + 1'b1;
                if (r_cnt == SAT_V - 1'b1) begin
                    r_armed  <= 1'b1;
                    r_locked <= 1'b0;
                    r_idle   <= r_locked;
                end
            end
        end
    end

    assign o_bit      = r_bit;
    assign o_bit_stb  = r_stb;
    assign o_line_err = r_lerr;
    assign o_idle     = r_idle;
    assign o_locked   = r_locked;
endmodule

// File: rtl/em4100_rx_decoder.sv
// EM4100 receiver: header hunt, 55-bit frame capture and parity check; ID delivered LSB first.
// valid/err pulse 2 clk after the stop-bit strobe; no backpressure, results are single-cycle pulses.
module em4100_rx_decoder
    import em4100_pkg::*;
#(
    parameter int HALF_CYC = 16,
    parameter int TOL      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_din,
    output logic [ID_BITS-1:0] o_data_out,
    output logic               o_valid,
    output logic               o_err,
    output logic [1:0]         o_err_code,
    output logic               o_locked
);
    logic w_bit, w_stb, w_lerr, w_idle;
    logic w_row_ok, w_col_ok, w_stop_ok;

    frame_state_t            r_state;
    logic [3:0]              r_ones;
    logic [5:0]              r_bit_cnt;
    logic [FRAME_BITS-1:0]   r_frame;
    logic [ID_BITS-1:0]      r_data_out;
    logic                    r_valid, r_err;
    logic [1:0]              r_code;

    em4100_manchester_rx #(.HALF_CYC(HALF_CYC), .TOL(TOL)) u_mrx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_din      (i_din),
        .o_bit      (w_bit),
        .o_bit_stb  (w_stb),
        .o_line_err (w_lerr),
        .o_idle     (w_idle),
        .o_locked   (o_locked)
    );

    assign w_row_ok  = row_par_ok(r_frame);
    assign w_col_ok  = col_par_ok(r_frame);
    assign w_stop_ok = ~r_frame[FRAME_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_ones     <= '0;
            r_bit_cnt  <= '0;
            r_frame    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= ERR_STOP;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (!i_en) begin
                r_state <= ST_HUNT;
                r_ones  <= '0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_lerr || w_idle) begin
                            r_ones <= '0;
                        end else if (w_stb) begin
                            if (!w_bit) begin
                                r_ones <= '0;
                            end else if (r_ones == 4'(HEADER_LEN-1)) begin
                                r_ones    <= '0;
                                r_bit_cnt <= '0;
                                r_state   <= ST_DATA;
                            end else begin
                                r_ones <= r_ones + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_lerr || w_idle) begin
                            r_err   <= 1'b1;
                            r_code  <= ERR_LINE;
                            r_state <= ST_HUNT;
                        end else if (w_stb) begin
                            r_frame[r_bit_cnt] <= w_bit;
                            if (r_bit_cnt == 6'(FRAME_BITS-1)) r_state <= ST_CHECK;
                            else r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        r_state <= ST_HUNT;
                        if (w_row_ok && w_col_ok && w_stop_ok) begin
                            r_data_out <= extract_id(r_frame);
                            r_valid    <= 1'b1;
                        end else begin
                            r_err  <= 1'b1;
                            r_code <= !w_row_ok ? ERR_ROW : (!w_col_ok ? ERR_COL : ERR_STOP);
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign o_data_out = r_data_out;
    assign o_valid    = r_valid;
    assign o_err      = r_err;
    assign o_err_code = r_code;
endmodule

// File: tb/tb_em4100_rx_decoder.sv
// Directed bench: a tag model Manchester-encodes frames (idle low between them) and the
// decoder's pulses, ID, error code and lock state are compared with hand-derived values.
module tb_em4100_rx_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        din = 1'b0;
    logic [39:0] data_out;
    logic        valid, err, locked;
    logic [1:0]  err_code;

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;

    always #5 clk = ~clk;

    em4100_rx_decoder #(.HALF_CYC(16), .TOL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_din      (din),
        .o_data_out (data_out),
        .o_valid    (valid),
        .o_err      (err),
        .o_err_code (err_code),
        .o_locked   (locked)
    );

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (err) n_err++;
        if (valid && err) n_both++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Transmit order: 9 header ones, 10 x (4 data + even parity), 4 column parity, stop.
    function automatic logic [63:0] encode(input logic [39:0] id, input int flip);
        logic [63:0] f;
        logic [3:0]  col;
        f   = '0;
        col = '0;
        for (int i = 0; i < 9; i++) f[i] = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 4; c++) f[9 + 5*r + c] = id[4*r + c];
            f[9 + 5*r + 4] = ^id[4*r +: 4];
            col = col ^ id[4*r +: 4];
        end
        for (int c = 0; c < 4; c++) f[59 + c] = col[c];
        f[63] = 1'b0;
        if (flip >= 0) f[flip] = ~f[flip];
        return f;
    endfunction

    // Bit value is the second-half level; gl inserts a 5-cycle pulse, sh shortens a first half to 11.
    task automatic send_frame(input logic [63:0] f, input int h1, input int h2,
                              input int gl, input int sh, input int nb);
        for (int i = 0; i < nb; i++) begin
            if (i == gl) begin
                din = ~f[i]; wait_cyc(5);
                din = f[i];  wait_cyc(5);
                din = ~f[i]; wait_cyc(h1 - 10);
            end else begin
                din = ~f[i];
                wait_cyc((i == sh) ? 11 : h1);
            end
            din = f[i];
            wait_cyc(h2);
        end
    endtask

    task automatic expect_good(input string tag, input logic [63:0] f, input int h1, input int h2,
                               input logic [39:0] id);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(f, h1, h2, -1, -1, 64);
        wait_cyc(20);
        check({tag, "_valid_cnt"}, 64'(n_valid - v0), 64'd1);
        check({tag, "_err_cnt"}, 64'(n_err - e0), 64'd0);
        check({tag, "_data"}, {24'd0, data_out}, {24'd0, id});
        din = 1'b0;
        wait_cyc(60);
    endtask

    task automatic expect_bad(input string tag, input logic [63:0] f, input int gl, input int sh,
                              input logic [1:0] code, input logic [39:0] keep);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(f, 16, 16, gl, sh, 64);
        wait_cyc(20);
        check({tag, "_err_cnt"}, 64'(n_err - e0), 64'd1);
        check({tag, "_valid_cnt"}, 64'(n_valid - v0), 64'd0);
        check({tag, "_code"}, {62'd0, err_code}, {62'd0, code});
        check({tag, "_data_kept"}, {24'd0, data_out}, {24'd0, keep});
        din = 1'b0;
        wait_cyc(60);
    endtask

    localparam logic [39:0] ID_A  = 40'h123456789A;
    localparam logic [39:0] ID_FF = 40'hFFFFFFFFFF;
    localparam logic [39:0] ID_J1 = 40'hA5A5A5A5A5;
    localparam logic [39:0] ID_J2 = 40'h0F1E2D3C4B;
    localparam logic [39:0] ID_1  = 40'h0000000001;
    localparam logic [39:0] ID_B2 = 40'hC3C3C3C3C3;

    initial begin
        int v0, e0;
        #1;
        check("rst_data", {24'd0, data_out}, 64'd0);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_code", {62'd0, err_code}, 64'd0);
        check("rst_locked", {63'd0, locked}, 64'd0);
        wait_cyc(5);
        rst_n = 1'b1;
        en    = 1'b1;
        wait_cyc(60);

        // Clean frame, lock held at end of frame, then lost after idle.
        v0 = n_valid;
        send_frame(encode(ID_A, -1), 16, 16, -1, -1, 64);
        check("clean_locked", {63'd0, locked}, 64'd1);
        wait_cyc(20);
        check("clean_valid_cnt", 64'(n_valid - v0), 64'd1);
        check("clean_err_cnt", 64'(n_err), 64'd0);
        check("clean_data", {24'd0, data_out}, {24'd0, ID_A});
        wait_cyc(40);
        check("idle_unlock", {63'd0, locked}, 64'd0);

        expect_bad("rowpar", encode(ID_A, 28), -1, -1, 2'b10, ID_A);
        expect_bad("colpar", encode(ID_A, 61), -1, -1, 2'b11, ID_A);
        expect_bad("stop", encode(ID_A, 63), -1, -1, 2'b00, ID_A);

        // Glitch at data bit 20: line error, lock lost, remaining edges ignored.
        v0 = n_valid;
        e0 = n_err;
        send_frame(encode(ID_A, -1), 16, 16, 29, -1, 64);
        check("glitch_locked", {63'd0, locked}, 64'd0);
        wait_cyc(20);
        check("glitch_err_cnt", 64'(n_err - e0), 64'd1);
        check("glitch_valid_cnt", 64'(n_valid - v0), 64'd0);
        check("glitch_code", {62'd0, err_code}, 64'd1);
        din = 1'b0;
        wait_cyc(60);
        expect_good("after_glitch", encode(ID_FF, -1), 16, 16, ID_FF);

        expect_good("jit_12_20", encode(ID_J1, -1), 12, 20, ID_J1);
        expect_good("jit_20_12", encode(ID_J2, -1), 20, 12, ID_J2);
        expect_bad("run11", encode(ID_A, -1), -1, 29, 2'b01, ID_J2);

        // Disable mid-frame: silent discard, ID kept.
        v0 = n_valid;
        e0 = n_err;
        send_frame(encode(ID_A, -1), 16, 16, -1, -1, 30);
        en = 1'b0;
        wait_cyc(3);
        check("en_locked", {63'd0, locked}, 64'd0);
        din = 1'b0;
        wait_cyc(40);
        check("en_no_pulse", 64'(n_valid - v0 + n_err - e0), 64'd0);
        check("en_data_kept", {24'd0, data_out}, {24'd0, ID_J2});
        en = 1'b1;
        wait_cyc(60);

        // Reset at data bit 30 clears everything at once.
        send_frame(encode(ID_A, -1), 16, 16, -1, -1, 39);
        din = 1'b0;
        wait_cyc(8);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, data_out}, 64'd0);
        check("midrst_locked", {63'd0, locked}, 64'd0);
        check("midrst_valid", {63'd0, valid}, 64'd0);
        check("midrst_err", {63'd0, err}, 64'd0);
        check("midrst_code", {62'd0, err_code}, 64'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(60);
        expect_good("post_rst", encode(ID_1, -1), 16, 16, ID_1);

        // Back-to-back frames with no idle gap.
        v0 = n_valid;
        e0 = n_err;
        send_frame(encode(ID_A, -1), 16, 16, -1, -1, 64);
        send_frame(encode(ID_B2, -1), 16, 16, -1, -1, 64);
        wait_cyc(20);
        check("b2b_valid_cnt", 64'(n_valid - v0), 64'd2);
        check("b2b_err_cnt", 64'(n_err - e0), 64'd0);
        check("b2b_data", {24'd0, data_out}, {24'd0, ID_B2});
        check("valid_err_overlap", 64'(n_both), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
